// File: rtl/l1_cache_controller.sv
// l1_cache_controller: miss-handling FSM of a direct-mapped, write-back, write-allocate L1 data cache
//   clk          : clock, state changes on the rising edge
//   rst          : asynchronous active-low reset
//   req_cs       : CPU access request, held until stall is low
//   req_we       : 1 = store, 0 = load
//   cache_hit    : tag match and valid at the current index
//   cache_dirty  : dirty bit of the line at the current index
//   mem_ack      : external memory finished the current line transfer
//   sram_cs      : tag/data SRAM chip select
//   sram_we      : tag/data SRAM write enable
//   sram_fill    : 1 = write refill line, 0 = merge CPU word
//   dirty_o      : dirty bit written with the tag
//   mem_cs       : external memory request
//   mem_we       : external memory write (victim write-back)
//   mem_addr_sel : 1 = victim address, 0 = request address
//   stall        : freeze the CPU pipeline
module l1_cache_controller (
    input  logic clk,
    input  logic rst,
    input  logic req_cs,
    input  logic req_we,
    input  logic cache_hit,
    input  logic cache_dirty,
    input  logic mem_ack,
    output logic sram_cs,
    output logic sram_we,
    output logic sram_fill,
    output logic dirty_o,
    output logic mem_cs,
    output logic mem_we,
    output logic mem_addr_sel,
    output logic stall
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILL    = 2'd3
    } state_t;
    state_t r_state;
    state_t w_next;
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    // Outputs are gated by rst so they drop the instant reset asserts, not at the next edge.
    always_comb begin
        w_next       = r_state;
        sram_cs      = 1'b0;
        sram_we      = 1'b0;
        sram_fill    = 1'b0;
        dirty_o      = 1'b0;
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        stall        = 1'b0;
        if (rst) begin
            case (r_state)
                IDLE: if (req_cs) begin
                    sram_cs = 1'b1;
                    if (cache_hit) begin
                        sram_we = req_we;
                        dirty_o = req_we;
                    end else begin
                        stall  = 1'b1;
                        w_next = cache_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    mem_cs       = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_sel = 1'b1;
                    stall        = 1'b1;
                    w_next       = mem_ack ? ALLOCATE : WRITEBACK;
                end
                ALLOCATE: begin
                    mem_cs = 1'b1;
                    stall  = 1'b1;
                    w_next = mem_ack ? REFILL : ALLOCATE;
                end
                default: begin
                    sram_cs   = 1'b1;
                    sram_we   = 1'b1;
                    sram_fill = 1'b1;
                    stall     = 1'b1;
                    w_next    = IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l1_cache_controller.sv
// tb_l1_cache_controller: directed self-checking bench for l1_cache_controller
module tb_l1_cache_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic req_cs = 1'b0, req_we = 1'b0, cache_hit = 1'b0, cache_dirty = 1'b0, mem_ack = 1'b0;
    logic sram_cs, sram_we, sram_fill, dirty_o, mem_cs, mem_we, mem_addr_sel, stall;
    logic [7:0] outs;
    int checks = 0;
    int failures = 0;
    // Output vector: {sram_cs,sram_we,sram_fill,dirty_o,mem_cs,mem_we,mem_addr_sel,stall}
    localparam logic [7:0] O_NONE  = 8'b0000_0000;
    localparam logic [7:0] O_RHIT  = 8'b1000_0000;
    localparam logic [7:0] O_WHIT  = 8'b1101_0000;
    localparam logic [7:0] O_MISS  = 8'b1000_0001;
    localparam logic [7:0] O_WB    = 8'b0000_1111;
    localparam logic [7:0] O_ALLOC = 8'b0000_1001;
    localparam logic [7:0] O_FILL  = 8'b1110_0001;
    always #5 clk = ~clk;
    assign outs = {sram_cs, sram_we, sram_fill, dirty_o, mem_cs, mem_we, mem_addr_sel, stall};
    l1_cache_controller dut (
        .clk(clk), .rst(rst), .req_cs(req_cs), .req_we(req_we), .cache_hit(cache_hit),
        .cache_dirty(cache_dirty), .mem_ack(mem_ack), .sram_cs(sram_cs), .sram_we(sram_we),
        .sram_fill(sram_fill), .dirty_o(dirty_o), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .stall(stall)
    );
    task automatic test_reset();
        {req_cs, req_we, cache_hit, cache_dirty, mem_ack} = 5'b10100;
        @(negedge clk);
        checks++;
        if (outs !== O_NONE) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs, O_NONE); end
        checks++;
        if (dut.r_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dut.r_state); end
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== O_RHIT) begin failures++; $display("FAIL reset_release_hit got=%b exp=%b", outs, O_RHIT); end
    endtask
    task automatic test_read_hit();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {req_cs, req_we, cache_hit, cache_dirty, mem_ack} = 5'b10110;
            #1;
            checks++;
            if (outs !== O_RHIT) begin failures++; $display("FAIL read_hit[%0d] got=%b exp=%b", i, outs, O_RHIT); end
        end
    endtask
    task automatic test_write_hit();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            {req_cs, req_we, cache_hit, cache_dirty, mem_ack} = 5'b11100;
            #1;
            checks++;
            if (outs !== O_WHIT) begin failures++; $display("FAIL write_hit[%0d] got=%b exp=%b", i, outs, O_WHIT); end
        end
    endtask
    task automatic test_clean_miss();
        logic [4:0] s [6];
        logic [7:0] e [6];
        int stalls = 0;
        s = '{5'b10000, 5'b10000, 5'b10000, 5'b10001, 5'b10001, 5'b10100};
        e = '{O_MISS, O_ALLOC, O_ALLOC, O_ALLOC, O_FILL, O_RHIT};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            {req_cs, req_we, cache_hit, cache_dirty, mem_ack} = s[i];
            #1;
            stalls += int'(stall);
            checks++;
            if (outs !== e[i]) begin failures++; $display("FAIL clean_miss[%0d] got=%b exp=%b", i, outs, e[i]); end
        end
        checks++;
        if (stalls != 5) begin failures++; $display("FAIL clean_miss_stalls got=%0d exp=5", stalls); end
    endtask
    task automatic test_dirty_miss();
        logic [4:0] s [7];
        logic [7:0] e [7];
        s = '{5'b11010, 5'b11010, 5'b11011, 5'b11010, 5'b11011, 5'b11000, 5'b11100};
        e = '{O_MISS, O_WB, O_WB, O_ALLOC, O_ALLOC, O_FILL, O_WHIT};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            {req_cs, req_we, cache_hit, cache_dirty, mem_ack} = s[i];
            #1;
            checks++;
            if (outs !== e[i]) begin failures++; $display("FAIL dirty_miss[%0d] got=%b exp=%b", i, outs, e[i]); end
        end
    endtask
    task automatic test_back_to_back();
        logic [4:0] s [5];
        logic [7:0] e [5];
        s = '{5'b00001, 5'b00001, 5'b10100, 5'b11100, 5'b00000};
        e = '{O_NONE, O_NONE, O_RHIT, O_WHIT, O_NONE};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            {req_cs, req_we, cache_hit, cache_dirty, mem_ack} = s[i];
            #1;
            checks++;
            if (outs !== e[i]) begin failures++; $display("FAIL back_to_back[%0d] got=%b exp=%b", i, outs, e[i]); end
        end
    endtask
    task automatic test_reset_mid_miss();
        @(negedge clk);
        {req_cs, req_we, cache_hit, cache_dirty, mem_ack} = 5'b10000;
        @(negedge clk);
        req_cs = 1'b0;
        #1;
        checks++;
        if (outs !== O_ALLOC) begin failures++; $display("FAIL drop_req_alloc got=%b exp=%b", outs, O_ALLOC); end
        @(negedge clk);
        #1;
        checks++;
        if (outs !== O_ALLOC) begin failures++; $display("FAIL drop_req_hold got=%b exp=%b", outs, O_ALLOC); end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_cs !== 1'b0 || outs !== O_NONE) begin failures++; $display("FAIL mid_miss_reset_outs got=%b exp=%b", outs, O_NONE); end
        checks++;
        if (dut.r_state !== 2'd0) begin failures++; $display("FAIL mid_miss_reset_state got=%0d exp=0", dut.r_state); end
        @(negedge clk);
        rst = 1'b1;
        {req_cs, req_we, cache_hit, cache_dirty, mem_ack} = 5'b10101;
        #1;
        checks++;
        if (outs !== O_RHIT) begin failures++; $display("FAIL post_reset_hit got=%b exp=%b", outs, O_RHIT); end
    endtask
    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_clean_miss();
        test_dirty_miss();
        test_back_to_back();
        test_reset_mid_miss();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
